// File: rtl/sdram_arb_pkg.sv
// ============================================================================
//  Module   : sdram_arb_pkg
//  Brief    : Shared types and default widths for the SDRAM burst arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

    localparam int c_addr_w = 22;
    localparam int c_len_w  = 9;
    localparam int c_lvl_w  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/sdram_addr_ptr.sv
// ============================================================================
//  Module   : sdram_addr_ptr
//  Brief    : Frame address pointer with deferred base load, wrap and done pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_addr_ptr
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int LEN_W  = c_len_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_apply,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_max_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_ptr_eff,
    output logic              o_frame_done
);

    localparam int c_sum_w = ADDR_W + 1;

    logic [ADDR_W-1:0]  r_ptr;
    logic               r_load_pend;
    logic               r_frame_done;
    logic [c_sum_w-1:0] w_next;
    logic               w_wrap;

    assign w_next = {1'b0, r_ptr} + c_sum_w'(i_len);
    assign w_wrap = (w_next >= {1'b0, i_max_addr});

    // A pending load takes effect in the same ARB cycle that issues the grant.
    assign o_ptr_eff    = r_load_pend ? i_base : r_ptr;
    assign o_frame_done = r_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_load_pend  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= i_advance && w_wrap;
            r_load_pend  <= i_load || (r_load_pend && !i_apply);
            if (i_advance) begin
                r_ptr <= w_wrap ? i_base : w_next[ADDR_W-1:0];
            end else if (i_apply && r_load_pend) begin
                r_ptr <= i_base;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
// ============================================================================
//  Module   : sdram_burst_arbiter
//  Brief    : Schedules SDRAM bursts between camera write and display read FIFOs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = c_addr_w,
    parameter int LEN_W     = c_len_w,
    parameter int LVL_W     = c_lvl_w,
    parameter int RD_URGENT = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rd_enable,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    input  logic [LEN_W-1:0]  wr_length,
    input  logic [LEN_W-1:0]  rd_length,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic              wr_load,
    input  logic              rd_load,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic              burst_done,
    output logic              frame_write_done,
    output logic              frame_read_done
);

    localparam int c_cmp_w = ((LVL_W > LEN_W) ? LVL_W : LEN_W) + 1;

    arb_state_t        r_state;
    grant_t            r_last_grant;
    grant_t            r_cur_grant;

    logic [LVL_W-1:0]  w_rd_free;
    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_rd_urgent;
    logic              w_any;
    grant_t            w_grant;
    logic              w_apply;
    logic              w_done_ok;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;

    // Free space in the read FIFO is (2^LVL_W - 1) - level, i.e. the inverted level.
    assign w_rd_free   = ~rd_fifo_level;
    assign w_wr_elig   = c_cmp_w'(wr_fifo_level) >= c_cmp_w'(wr_length);
    assign w_rd_elig   = rd_enable && (c_cmp_w'(w_rd_free) >= c_cmp_w'(rd_length));
    assign w_rd_urgent = rd_fifo_level < LVL_W'(RD_URGENT);
    assign w_any       = w_wr_elig || w_rd_elig;

    always_comb begin
        w_grant = GRANT_WR;
        if (w_rd_elig && w_rd_urgent) begin
            w_grant = GRANT_RD;
        end else if (w_rd_elig && !w_wr_elig) begin
            w_grant = GRANT_RD;
        end else if (w_rd_elig && w_wr_elig) begin
            w_grant = (r_last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
        end
    end

    assign w_apply   = (r_state == ST_IDLE) || (r_state == ST_ARB);
    assign w_done_ok = burst_done &&
                       ((r_state == ST_WAIT) || ((r_state == ST_ISSUE) && cmd_ready));

    sdram_addr_ptr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_wr_ptr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (wr_load),
        .i_apply      (w_apply),
        .i_base       (wr_addr),
        .i_max_addr   (wr_max_addr),
        .i_len        (wr_length),
        .i_advance    (w_done_ok && (r_cur_grant == GRANT_WR)),
        .o_ptr_eff    (w_wr_ptr),
        .o_frame_done (frame_write_done)
    );

    sdram_addr_ptr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_rd_ptr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (rd_load),
        .i_apply      (w_apply),
        .i_base       (rd_addr),
        .i_max_addr   (rd_max_addr),
        .i_len        (rd_length),
        .i_advance    (w_done_ok && (r_cur_grant == GRANT_RD)),
        .o_ptr_eff    (w_rd_ptr),
        .o_frame_done (frame_read_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_RD;
            r_cur_grant  <= GRANT_RD;
            cmd_valid    <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init_done) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (w_any) begin
                        cmd_valid    <= 1'b1;
                        cmd_write    <= (w_grant == GRANT_WR);
                        cmd_addr     <= (w_grant == GRANT_WR) ? w_wr_ptr : w_rd_ptr;
                        cmd_len      <= (w_grant == GRANT_WR) ? wr_length : rd_length;
                        r_last_grant <= w_grant;
                        r_cur_grant  <= w_grant;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        r_state   <= burst_done ? ST_ARB : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (burst_done) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
// ============================================================================
//  Module   : tb_sdram_burst_arbiter
//  Brief    : Directed, table-driven bench for the SDRAM burst arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_burst_arbiter;
    import sdram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        rd_enable;
    logic [9:0]  wr_fifo_level;
    logic [9:0]  rd_fifo_level;
    logic [8:0]  wr_length;
    logic [8:0]  rd_length;
    logic [21:0] wr_addr;
    logic [21:0] wr_max_addr;
    logic [21:0] rd_addr;
    logic [21:0] rd_max_addr;
    logic        wr_load;
    logic        rd_load;
    logic        cmd_valid;
    logic        cmd_write;
    logic [21:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        cmd_ready;
    logic        burst_done;
    logic        frame_write_done;
    logic        frame_read_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_burst_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .init_done        (init_done),
        .rd_enable        (rd_enable),
        .wr_fifo_level    (wr_fifo_level),
        .rd_fifo_level    (rd_fifo_level),
        .wr_length        (wr_length),
        .rd_length        (rd_length),
        .wr_addr          (wr_addr),
        .wr_max_addr      (wr_max_addr),
        .rd_addr          (rd_addr),
        .rd_max_addr      (rd_max_addr),
        .wr_load          (wr_load),
        .rd_load          (rd_load),
        .cmd_valid        (cmd_valid),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .cmd_ready        (cmd_ready),
        .burst_done       (burst_done),
        .frame_write_done (frame_write_done),
        .frame_read_done  (frame_read_done)
    );

    typedef struct {
        logic       rd_en;
        logic [9:0] wl;
        logic [9:0] rl;
        logic [8:0] wlen;
        logic [8:0] rlen;
        logic       ev;
        logic       ew;
    } vec_t;

    vec_t        vecs[14];
    logic [21:0] wr_m;
    logic [21:0] rd_m;
    logic [21:0] ea;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        rd_enable     = 1'b0;
        wr_fifo_level = '0;
        rd_fifo_level = '0;
    endtask

    // Inputs were driven on the previous falling edge; one ARB edge later the command shows.
    task automatic issue_check(input string nm, input logic ew, input logic [21:0] ea_i,
                               input logic [8:0] el);
        @(negedge clk);
        chk({nm, ".valid"}, cmd_valid, 1'b1);
        chk({nm, ".write"}, cmd_write, ew);
        chk({nm, ".addr"},  cmd_addr,  ea_i);
        chk({nm, ".len"},   cmd_len,   el);
    endtask

    task automatic finish_joint();
        set_idle();
        cmd_ready  = 1'b1;
        burst_done = 1'b1;
        @(negedge clk);
        cmd_ready  = 1'b0;
        burst_done = 1'b0;
    endtask

    task automatic finish_split();
        set_idle();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready  = 1'b0;
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
    endtask

    initial begin
        //           rd_en  wl       rl       wlen    rlen    ev    ew
        vecs[0]  = '{1'b0, 10'd300, 10'd0,   9'd256, 9'd256, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 10'd300, 10'd200, 9'd256, 9'd256, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 10'd300, 10'd200, 9'd256, 9'd256, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 10'd300, 10'd200, 9'd256, 9'd256, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 10'd900, 10'd50,  9'd256, 9'd256, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 10'd900, 10'd50,  9'd256, 9'd256, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 10'd900, 10'd127, 9'd256, 9'd256, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 10'd900, 10'd128, 9'd256, 9'd256, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 10'd255, 10'd0,   9'd256, 9'd256, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10'd0,   10'd769, 9'd256, 9'd256, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 10'd0,   10'd767, 9'd256, 9'd256, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 10'd10,  10'd0,   9'd10,  9'd256, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 10'd300, 10'd50,  9'd256, 9'd256, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 10'd0,   10'd0,   9'd256, 9'd8,   1'b1, 1'b0};

        rst = 1'b1; init_done = 1'b0; set_idle();
        wr_length = 9'd256; rd_length = 9'd256;
        wr_addr = 22'h010000; wr_max_addr = 22'h3FFFFF;
        rd_addr = 22'h200000; rd_max_addr = 22'h3FFFFF;
        wr_load = 1'b0; rd_load = 1'b0; cmd_ready = 1'b0; burst_done = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset.valid", cmd_valid, 1'b0);
        chk("reset.write", cmd_write, 1'b0);
        chk("reset.addr",  cmd_addr,  22'h0);
        chk("reset.len",   cmd_len,   9'h0);
        chk("reset.fdone", {frame_write_done, frame_read_done}, 2'b00);

        // Load both frame bases while still waiting for init.
        rst = 1'b0; wr_load = 1'b1; rd_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0; rd_load = 1'b0;
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        chk("idle_to_arb.valid", cmd_valid, 1'b0);

        wr_m = 22'h010000;
        rd_m = 22'h200000;
        for (int i = 0; i < 14; i++) begin
            rd_enable     = vecs[i].rd_en;
            wr_fifo_level = vecs[i].wl;
            rd_fifo_level = vecs[i].rl;
            wr_length     = vecs[i].wlen;
            rd_length     = vecs[i].rlen;
            if (vecs[i].ev) begin
                ea = vecs[i].ew ? wr_m : rd_m;
                issue_check($sformatf("vec%0d", i), vecs[i].ew, ea,
                            vecs[i].ew ? vecs[i].wlen : vecs[i].rlen);
                if (vecs[i].ew) wr_m = wr_m + 22'(vecs[i].wlen);
                else            rd_m = rd_m + 22'(vecs[i].rlen);
                finish_joint();
            end else begin
                repeat (3) begin
                    @(negedge clk);
                    chk($sformatf("vec%0d.no_grant", i), cmd_valid, 1'b0);
                end
                set_idle();
            end
        end

        // Write-only frame of two bursts, wrapping exactly at the limit.
        wr_addr = 22'h0; wr_max_addr = 22'd512; wr_length = 9'd256; wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        @(negedge clk);
        wr_fifo_level = 10'd300;
        issue_check("wrap.b0", 1'b1, 22'h0, 9'd256);
        finish_split();
        chk("wrap.b0.fdone", frame_write_done, 1'b0);
        wr_fifo_level = 10'd300;
        issue_check("wrap.b1", 1'b1, 22'd256, 9'd256);
        finish_split();
        chk("wrap.b1.fdone", frame_write_done, 1'b1);
        wr_fifo_level = 10'd300;
        issue_check("wrap.b2", 1'b1, 22'h0, 9'd256);
        chk("wrap.fdone_one_cycle", frame_write_done, 1'b0);
        wr_max_addr = 22'h3FFFFF;
        finish_split();
        chk("wrap.b2.fdone", frame_write_done, 1'b0);

        // Load arrives mid-burst: the burst still advances, then the base takes over.
        wr_fifo_level = 10'd300;
        issue_check("load.b0", 1'b1, 22'd256, 9'd256);
        set_idle();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0; wr_addr = 22'h100000; wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0; burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        chk("load.ptr_advanced", dut.u_wr_ptr.r_ptr, 22'd512);
        chk("load.fdone", frame_write_done, 1'b0);
        wr_fifo_level = 10'd300;
        issue_check("load.b1", 1'b1, 22'h100000, 9'd256);
        finish_joint();

        // Controller stalls the read command for ten cycles.
        rd_length = 9'd256; rd_enable = 1'b1; rd_fifo_level = 10'd200;
        issue_check("stall.rd", 1'b0, rd_m, 9'd256);
        set_idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("stall.c%0d", k), {cmd_valid, cmd_write, cmd_len, cmd_addr},
                {1'b1, 1'b0, 9'd256, rd_m});
        end
        rd_m = rd_m + 22'd256;
        finish_joint();
        chk("stall.drop", cmd_valid, 1'b0);
        chk("stall.state", dut.r_state, ST_ARB);
        rd_enable = 1'b1; rd_fifo_level = 10'd200;
        issue_check("stall.next", 1'b0, rd_m, 9'd256);

        // Reset with a read burst in flight.
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        rd_enable = 1'b1; rd_fifo_level = 10'd200; rst = 1'b1;
        @(negedge clk);
        chk("rst.outs", {cmd_valid, cmd_write, cmd_addr, cmd_len, frame_write_done,
                         frame_read_done}, 35'h0);
        chk("rst.state", dut.r_state, ST_IDLE);
        rst = 1'b0; init_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst.no_init", cmd_valid, 1'b0);
        end
        init_done = 1'b1;
        @(negedge clk);
        chk("rst.arb_entry", cmd_valid, 1'b0);
        issue_check("rst.rd", 1'b0, 22'h0, 9'd256);
        finish_joint();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
